// File: rtl/mem_read_sequencer.sv
// mem_read_sequencer: read-side controller for the 4x4 operand memory.
// A start request launches a skewed, diagonal read pattern. Line k begins
// one step after line k-1, so all four lines stream into the systolic array
// in 7 feed steps. All outputs are registered.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | outputs zero, waiting for start (reverse captured with it)
// FEED  | step t = 0..6; line k enabled while k <= t <= k+3
// DONE  | single-cycle done pulse, then back to IDLE unconditionally
module mem_read_sequencer #(
    parameter int LINES = 4,
    parameter int ELEMS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 reverse_i,
    input  logic                 stall_i,
    output logic [LINES-1:0]     read_enable_o,
    output logic [2*LINES-1:0]   read_elem_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2:0]           step_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FEED = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] LAST_STEP = 3'(LINES + ELEMS - 2);
    localparam logic [2:0] LAST_ELEM = 3'(ELEMS - 1);

    logic [1:0]           state_q, state_d;
    logic [2:0]           step_q, step_d;
    logic                 rev_q, rev_d;

    logic [LINES-1:0]     read_enable_d;
    logic [2*LINES-1:0]   read_elem_d;
    logic                 busy_d;
    logic                 done_d;
    logic [2:0]           step_out_d;

    logic [2:0]           diff;
    logic [1:0]           elem;

    // Sequencer next-state: step advances only when FEED is not stalled.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rev_d   = rev_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FEED;
                    step_d  = 3'd0;
                    rev_d   = reverse_i;
                end
            end
            S_FEED: begin
                if (!stall_i) begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                        step_d  = 3'd0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                step_d  = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state so
    // that every output is a plain register with no decode after the flop.
    always_comb begin
        read_enable_d = '0;
        read_elem_d   = '0;
        busy_d        = (state_d == S_FEED);
        done_d        = (state_d == S_DONE);
        step_out_d    = (state_d == S_FEED) ? step_d : 3'd0;
        diff          = 3'd0;
        elem          = 2'd0;
        if (state_d == S_FEED) begin
            for (int k = 0; k < LINES; k++) begin
                diff = step_d - 3'(k);
                if ((step_d >= 3'(k)) && (diff <= LAST_ELEM)) begin
                    read_enable_d[k]  = 1'b1;
                    elem              = diff[1:0];
                    read_elem_d[2*k +: 2] = rev_d ? (LAST_ELEM[1:0] - elem) : elem;
                end
            end
        end
    end

    // State and output registers; reset aborts any sequence without done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            step_q        <= 3'd0;
            rev_q         <= 1'b0;
            read_enable_o <= '0;
            read_elem_o   <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            step_o        <= 3'd0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            rev_q         <= rev_d;
            read_enable_o <= read_enable_d;
            read_elem_o   <= read_elem_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
            step_o        <= step_out_d;
        end
    end

endmodule

// File: tb/tb_mem_read_sequencer.sv
// tb_mem_read_sequencer: directed plus randomized bench for the read sequencer.
// Expected outputs come from a model that tracks how many elements each line
// has already read, rather than from the step arithmetic.
module tb_mem_read_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, reverse, stall;
    logic [3:0] read_enable;
    logic [7:0] read_elem;
    logic       busy, done;
    logic [2:0] step;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_read_sequencer #(.LINES(4), .ELEMS(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .reverse_i     (reverse),
        .stall_i       (stall),
        .read_enable_o (read_enable),
        .read_elem_o   (read_elem),
        .busy_o        (busy),
        .done_o        (done),
        .step_o        (step)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Enable window per feed step, written out as the diagonal wavefront.
    function automatic logic [3:0] en_tab(input int t);
        case (t)
            0: return 4'b0001;
            1: return 4'b0011;
            2: return 4'b0111;
            3: return 4'b1111;
            4: return 4'b1110;
            5: return 4'b1100;
            6: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // Model: mode 0 idle, 1 feeding, 2 done pulse; per-line read counts.
    int m_mode = 0;
    int m_t    = 0;
    bit m_rev  = 0;
    int m_cnt [4];
    bit m_valid = 0;

    initial begin
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_mode = 0;
                m_t    = 0;
                m_rev  = 0;
            end else begin
                case (m_mode)
                    0: if (start) begin
                        m_mode = 1;
                        m_t    = 0;
                        m_rev  = reverse;
                        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
                    end
                    1: if (!stall) begin
                        for (int k = 0; k < 4; k++)
                            if (en_tab(m_t)[k]) m_cnt[k]++;
                        if (m_t == 6) m_mode = 2;
                        else          m_t++;
                    end
                    default: m_mode = 0;
                endcase
            end
            m_valid = 1;
        end
    end

    // Every cycle: compare DUT outputs against the model.
    always @(negedge clk) begin : cmp
        logic [3:0] e_en;
        logic [7:0] e_elem;
        if (m_valid) begin
            e_en   = (m_mode == 1) ? en_tab(m_t) : 4'b0000;
            e_elem = 8'h00;
            for (int k = 0; k < 4; k++)
                if (e_en[k])
                    e_elem[2*k +: 2] = m_rev ? 2'(3 - m_cnt[k]) : 2'(m_cnt[k]);
            check("model_read_enable", 32'(read_enable), 32'(e_en));
            check("model_read_elem",   32'(read_elem),   32'(e_elem));
            check("model_busy",        32'(busy),        32'(m_mode == 1));
            check("model_done",        32'(done),        32'(m_mode == 2));
            check("model_step",        32'(step),        32'((m_mode == 1) ? m_t : 0));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: got no done after %0d cycles, required a done pulse", n);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_en"},   32'(read_enable), 32'h0);
        check({name, "_elem"}, 32'(read_elem),   32'h0);
        check({name, "_busy"}, 32'(busy),        32'h0);
        check({name, "_done"}, 32'(done),        32'h0);
        check({name, "_step"}, 32'(step),        32'h0);
    endtask

    initial begin
        int n;
        int last;
        int cnt;
        rst = 1'b1; start = 1'b1; reverse = 1'b0; stall = 1'b0;

        // Reset held two cycles with start high.
        repeat (2) @(posedge clk);
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check("fwd_t0_en",   32'(read_enable), 32'h1);
        check("fwd_t0_elem", 32'(read_elem),   32'h00);
        start = 1'b0;
        repeat (3) tick();
        check("fwd_t3_en",   32'(read_enable), 32'hF);
        check("fwd_t3_elem", 32'(read_elem),   32'h1B);
        check("fwd_t3_step", 32'(step),        32'd3);
        wait_done(n);
        check("fwd_done_latency", 32'(n), 32'd4);

        // Reverse sequence; reverse changes mid-FEED are ignored.
        tick();
        start = 1'b1; reverse = 1'b1;
        tick();
        check("rev_t0_en",   32'(read_enable), 32'h1);
        check("rev_t0_elem", 32'(read_elem),   32'h03);
        start = 1'b0; reverse = 1'b0;
        repeat (3) tick();
        check("rev_t3_elem", 32'(read_elem), 32'hE4);
        wait_done(n);
        check("rev_done_latency", 32'(n), 32'd4);

        // Stall two cycles at t2 and one at t6.
        tick();
        start = 1'b1; reverse = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        repeat (2) tick();
        stall = 1'b1;
        repeat (2) tick();
        check("stall_hold_step", 32'(step), 32'd2);
        stall = 1'b0;
        repeat (4) tick();
        check("stall_t6_step", 32'(step), 32'd6);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        wait_done(n);
        check("stall_done_latency", 32'(9 + n), 32'd10);

        // Start held high: done pulses every 9 cycles.
        tick();
        start = 1'b1;
        last = -1;
        cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            reverse = 1'($urandom_range(0, 1));
            tick();
            if (done === 1'b1) begin
                if (last >= 0) check("repeat_period", 32'(i - last), 32'd9);
                last = i;
                cnt++;
            end
        end
        check("repeat_done_count", 32'(cnt >= 4), 32'd1);
        start = 1'b0;
        repeat (10) tick();

        // Reset at t4 aborts without done; a following start runs fully.
        start = 1'b1; reverse = 1'b0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort_t4_step", 32'(step), 32'd4);
        rst = 1'b1;
        tick();
        check_zero("abort");
        rst = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("post_abort_latency", 32'(n), 32'd7);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            start   = ($urandom_range(0, 2) == 0);
            reverse = 1'($urandom_range(0, 1));
            stall   = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
